// File: rtl/apb_reg_slave.sv
// APB completer with eight 32-bit registers (reg 7 = read-only ID) and programmable wait states.
// Define APB_REG_SLAVE_SLVERR_EN to drive pslverr on bad accesses; otherwise pslverr stays 0.
module apb_reg_slave #(
    parameter int          SLAVE_ID    = 0,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [2:0]  pselx,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [31:0] ctrl_q
);

    typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;
    logic [31:0] prdata_q, prdata_d;
    logic [31:0] regs_q [0:6];
    logic [31:0] rd_val;
    logic        sel;
    logic        err_d;
    logic        commit;

    function automatic logic access_err(input logic [31:0] a, input logic wr);
        return (a[31:5] != 27'd0) || (a[1:0] != 2'd0) || (wr && (a[4:2] == 3'd7));
    endfunction

    assign sel = pselx[SLAVE_ID];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        case (state_q)
            IDLE: begin
                if (sel && !penable) begin
                    addr_d  = paddr;
                    write_d = pwrite;
                    wdata_d = pwdata;
                    cnt_d   = WAIT_CNT;
                    state_d = (WAIT_STATES > 0) ? WAIT : READY;
                end
            end
            WAIT: begin
                if (!sel) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = READY;
                    end
                end
            end
            READY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response is computed on entry to READY, so outputs come straight from flops.
    always_comb begin
        rd_val = ID_VALUE;
        for (int i = 0; i < 7; i++) begin
            if (addr_d[4:2] == 3'(i)) begin
                rd_val = regs_q[i];
            end
        end
        err_d     = access_err(addr_d, write_d);
        pready_d  = (state_d == READY);
        prdata_d  = (pready_d && !write_d && !err_d) ? rd_val : 32'd0;
`ifdef APB_REG_SLAVE_SLVERR_EN
        pslverr_d = pready_d && err_d;
`else
        pslverr_d = 1'b0;
`endif
    end

    assign commit = pready_q && sel && penable && write_q && !access_err(addr_q, write_q);

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            write_q   <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= 32'd0;
            ctrl_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            ctrl_q    <= regs_q[0];
        end
    end

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_reg
            always_ff @(posedge hclk) begin
                if (hreset) begin
                    regs_q[gi] <= 32'd0;
                end else if (commit && (addr_q[4:2] == 3'(gi))) begin
                    regs_q[gi] <= wdata_q;
                end
            end
        end
    endgenerate

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench for apb_reg_slave: one W=1 and one W=0 instance on a shared APB bus, checked each cycle
// against a transfer-level model, plus directed literal checks.
module tb_apb_reg_slave;

    localparam logic [31:0] ID = 32'hA5B0_0001;
`ifdef APB_REG_SLAVE_SLVERR_EN
    localparam logic SLV = 1'b1;
`else
    localparam logic SLV = 1'b0;
`endif

    logic        hclk = 1'b0;
    logic        s_rst = 1'b1;
    logic [2:0]  s_psel = 3'b000;
    logic        s_pen = 1'b0;
    logic        s_wr = 1'b0;
    logic [31:0] s_addr = 32'd0;
    logic [31:0] s_wdata = 32'd0;

    logic [31:0] a_prdata, b_prdata, a_ctrl, b_ctrl;
    logic        a_pready, b_pready, a_pslverr, b_pslverr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 hclk = ~hclk;

    apb_reg_slave #(.SLAVE_ID(0), .WAIT_STATES(1), .ID_VALUE(ID)) u_dut_a (
        .hclk(hclk), .hreset(s_rst), .pselx(s_psel), .penable(s_pen), .pwrite(s_wr),
        .paddr(s_addr), .pwdata(s_wdata), .prdata(a_prdata), .pready(a_pready),
        .pslverr(a_pslverr), .ctrl_q(a_ctrl)
    );

    // Select bit is mirrored so SLAVE_ID=2 sees the same sel as instance a.
    apb_reg_slave #(.SLAVE_ID(2), .WAIT_STATES(0), .ID_VALUE(ID)) u_dut_b (
        .hclk(hclk), .hreset(s_rst), .pselx({s_psel[0], s_psel[1], s_psel[2]}), .penable(s_pen),
        .pwrite(s_wr), .paddr(s_addr), .pwdata(s_wdata), .prdata(b_prdata), .pready(b_pready),
        .pslverr(b_pslverr), .ctrl_q(b_ctrl)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=0x%08h required=0x%08h", nm, $time, act, exp);
        end
    endtask

    // ---------------- transfer-level reference model ----------------
    logic [31:0] mem [2][8];
    logic        busy [2];
    int          left [2];
    logic        rq_wr [2];
    logic [31:0] rq_addr [2];
    logic [31:0] rq_data [2];
    logic        e_rdy [2];
    logic        e_err [2];
    logic [31:0] e_rd [2];
    logic [31:0] e_ctl [2];
    logic        mvalid = 1'b0;

    function automatic logic is_err(input logic wr, input logic [31:0] a);
        return (a[31:5] != 0) || (a[1:0] != 0) || (wr && a[4:2] == 3'd7);
    endfunction

    function automatic void respond(input int k);
        logic er;
        int   idx;
        er       = is_err(rq_wr[k], rq_addr[k]);
        idx      = int'(rq_addr[k][4:2]);
        e_rdy[k] = 1'b1;
        e_err[k] = SLV && er;
        e_rd[k]  = (!rq_wr[k] && !er) ? ((idx == 7) ? ID : mem[k][idx]) : 32'd0;
    endfunction

    always @(posedge hclk) begin
        for (int k = 0; k < 2; k++) begin
            int          w;
            logic        sel;
            logic        was_rdy;
            logic [31:0] old0;
            w   = (k == 0) ? 1 : 0;
            sel = s_psel[0];
            if (s_rst) begin
                for (int r = 0; r < 8; r++) mem[k][r] = 32'd0;
                busy[k] = 1'b0; left[k] = 0;
                e_rdy[k] = 1'b0; e_err[k] = 1'b0; e_rd[k] = 32'd0; e_ctl[k] = 32'd0;
            end else begin
                was_rdy = e_rdy[k];
                old0    = mem[k][0];
                if (was_rdy && sel && s_pen && rq_wr[k] && !is_err(rq_wr[k], rq_addr[k]))
                    mem[k][int'(rq_addr[k][4:2])] = rq_data[k];
                e_ctl[k] = old0;
                e_rdy[k] = 1'b0; e_err[k] = 1'b0; e_rd[k] = 32'd0;
                if (was_rdy) begin
                    busy[k] = 1'b0;
                end else if (busy[k]) begin
                    if (!sel) begin
                        busy[k] = 1'b0;
                    end else begin
                        left[k]--;
                        if (left[k] == 0) begin
                            busy[k] = 1'b0;
                            respond(k);
                        end
                    end
                end else if (sel && !s_pen) begin
                    rq_wr[k] = s_wr; rq_addr[k] = s_addr; rq_data[k] = s_wdata;
                    if (w == 0) respond(k);
                    else begin busy[k] = 1'b1; left[k] = w; end
                end
            end
        end
        if (s_rst) mvalid = 1'b1;
    end

    always @(negedge hclk) begin
        if (mvalid) begin
            chk("a_pready",  32'(a_pready),  32'(e_rdy[0]));
            chk("a_pslverr", 32'(a_pslverr), 32'(e_err[0]));
            chk("a_prdata",  a_prdata,       e_rd[0]);
            chk("a_ctrl_q",  a_ctrl,         e_ctl[0]);
            chk("b_pready",  32'(b_pready),  32'(e_rdy[1]));
            chk("b_pslverr", 32'(b_pslverr), 32'(e_err[1]));
            chk("b_prdata",  b_prdata,       e_rd[1]);
            chk("b_ctrl_q",  b_ctrl,         e_ctl[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input logic [2:0] ps, input logic en, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
        s_rst = r; s_psel = ps; s_pen = en; s_wr = w; s_addr = a; s_wdata = d;
        @(posedge hclk);
        #1;
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int hold, input int drop_at, input logic [2:0] ps,
                        output int a_lat, output logic [31:0] a_rd, output logic a_er,
                        output int b_lat, output logic [31:0] b_rd, output logic b_er);
        a_lat = -1; b_lat = -1; a_rd = 0; b_rd = 0; a_er = 0; b_er = 0;
        for (int h = 0; h <= hold; h++) begin
            step(1'b0, (h == drop_at && h > 0) ? 3'b000 : ps, (h > 0), w, a, d);
            if (a_pready && a_lat < 0) begin a_lat = h; a_rd = a_prdata; a_er = a_pslverr; end
            if (b_pready && b_lat < 0) begin b_lat = h; b_rd = b_prdata; b_er = b_pslverr; end
        end
        step(1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
        $display("xfer %s addr=%08h data=%08h hold=%0d drop=%0d a_lat=%0d a_rd=%08h b_lat=%0d b_rd=%08h",
                 w ? "WR" : "RD", a, d, hold, drop_at, a_lat, a_rd, b_lat, b_rd);
    endtask

    initial begin
        int          al, bl;
        logic [31:0] ard, brd;
        logic        aer, ber;

        step(1'b1, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 3'b001, 1'b1, 1'b1, 32'h8, 32'hFFFF_FFFF);
        chk("rst_a_pready",  32'(a_pready),  32'd0);
        chk("rst_a_pslverr", 32'(a_pslverr), 32'd0);
        chk("rst_a_prdata",  a_prdata,       32'd0);
        chk("rst_a_ctrl",    a_ctrl,         32'd0);
        chk("rst_b_pready",  32'(b_pready),  32'd0);
        step(1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);

        // write then read reg2
        xfer(1'b1, 32'h08, 32'h1234_5678, 2, 0, 3'b001, al, ard, aer, bl, brd, ber);
        chk("w1_latency", 32'(al), 32'd1);
        chk("w0_latency", 32'(bl), 32'd0);
        chk("wr08_err",   32'(aer), 32'd0);
        xfer(1'b0, 32'h08, 32'd0, 2, 0, 3'b001, al, ard, aer, bl, brd, ber);
        chk("rd08_a", ard, 32'h1234_5678);
        chk("rd08_b", brd, 32'h1234_5678);

        // ID register
        xfer(1'b0, 32'h1C, 32'd0, 2, 0, 3'b001, al, ard, aer, bl, brd, ber);
        chk("rd1c_id", ard, 32'hA5B0_0001);
        xfer(1'b1, 32'h1C, 32'hFFFF_FFFF, 2, 0, 3'b001, al, ard, aer, bl, brd, ber);
        chk("wr1c_err_a", 32'(aer), 32'(SLV));
        chk("wr1c_err_b", 32'(ber), 32'(SLV));
        xfer(1'b0, 32'h1C, 32'd0, 2, 0, 3'b001, al, ard, aer, bl, brd, ber);
        chk("rd1c_after", ard, 32'hA5B0_0001);

        // out-of-range and misaligned
        xfer(1'b0, 32'h40, 32'd0, 2, 0, 3'b001, al, ard, aer, bl, brd, ber);
        chk("rd40_err", 32'(aer), 32'(SLV));
        chk("rd40_data", ard, 32'd0);
        xfer(1'b1, 32'h06, 32'hCAFE_F00D, 2, 0, 3'b001, al, ard, aer, bl, brd, ber);
        chk("wr06_err", 32'(aer), 32'(SLV));
        xfer(1'b0, 32'h04, 32'd0, 2, 0, 3'b001, al, ard, aer, bl, brd, ber);
        chk("rd04_zero", ard, 32'd0);
        xfer(1'b0, 32'h08, 32'd0, 2, 0, 3'b001, al, ard, aer, bl, brd, ber);
        chk("rd08_keep", ard, 32'h1234_5678);

        // back-to-back zero-wait writes
        step(1'b0, 3'b001, 1'b0, 1'b1, 32'h00, 32'h1);
        chk("b2b_rdy1", 32'(b_pready), 32'd1);
        step(1'b0, 3'b001, 1'b1, 1'b1, 32'h00, 32'h1);
        step(1'b0, 3'b001, 1'b0, 1'b1, 32'h04, 32'h2);
        chk("b2b_rdy2", 32'(b_pready), 32'd1);
        step(1'b0, 3'b001, 1'b1, 1'b1, 32'h04, 32'h2);
        step(1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("b2b_ctrl_b", b_ctrl, 32'h1);
        chk("b2b_ctrl_a", a_ctrl, 32'h0);

        // sel dropped during WAIT
        step(1'b0, 3'b001, 1'b0, 1'b1, 32'h0C, 32'hDEAD);
        step(1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("drop_a_rdy", 32'(a_pready), 32'd0);
        xfer(1'b0, 32'h0C, 32'd0, 2, 0, 3'b001, al, ard, aer, bl, brd, ber);
        chk("drop_rd0c_a", ard, 32'd0);
        chk("drop_rd0c_b", brd, 32'd0);

        // reset while in READY
        step(1'b0, 3'b001, 1'b0, 1'b1, 32'h10, 32'h55);
        step(1'b0, 3'b001, 1'b1, 1'b1, 32'h10, 32'h55);
        chk("rdy_before_rst", 32'(a_pready), 32'd1);
        step(1'b1, 3'b001, 1'b1, 1'b1, 32'h10, 32'h55);
        chk("rst_rdy_pready", 32'(a_pready), 32'd0);
        chk("rst_rdy_prdata", a_prdata, 32'd0);
        chk("rst_rdy_ctrl_b", b_ctrl, 32'd0);
        step(1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
        xfer(1'b0, 32'h08, 32'd0, 2, 0, 3'b001, al, ard, aer, bl, brd, ber);
        chk("rst_cleared", ard, 32'd0);

        // randomized traffic, checked every cycle by the model
        for (int t = 0; t < 300; t++) begin
            int          r, ra, hold, drop;
            logic [31:0] a;
            logic [2:0]  ps;
            r  = int'($urandom_range(0, 99));
            ra = int'($urandom_range(0, 99));
            if (r < 3) begin
                step(1'b1, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
                step(1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
                $display("xfer RST");
            end else if (r < 6) begin
                step(1'b0, 3'b001, 1'b1, 1'b1, {27'd0, 3'($urandom_range(0, 6)), 2'b00}, $urandom);
                step(1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
                $display("xfer GLITCH penable-without-setup");
            end else begin
                if (ra < 70)      a = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
                else if (ra < 85) a = {27'd0, 5'($urandom)};
                else              a = $urandom;
                ps   = ($urandom_range(0, 9) == 0) ? 3'b010 : 3'b001;
                hold = int'($urandom_range(0, 3));
                drop = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
                xfer(1'($urandom), a, $urandom, hold, drop, ps, al, ard, aer, bl, brd, ber);
            end
        end

        repeat (3) step(1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
